// File: rtl/stack_pkg.sv
// Shared types for the operand stack: opcodes, error codes and control states.
// Imported by the stack core and by anything that drives or decodes it.
package stack_pkg;

   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_PUSH = 3'd1,
      OP_POP  = 3'd2,
      OP_DUP  = 3'd3,
      OP_SWAP = 3'd4,
      OP_ADD  = 3'd5,
      OP_SUB  = 3'd6,
      OP_CLR  = 3'd7
   } stack_op_t;

   typedef enum logic [1:0] {
      ERR_NONE      = 2'd0,
      ERR_OVERFLOW  = 2'd1,
      ERR_UNDERFLOW = 2'd2
   } err_code_t;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_ERROR = 1'b1
   } stack_state_t;

endpackage

// File: rtl/operand_stack.sv
// Register-array operand stack with arithmetic ops and a sticky error state.
// An accepted op updates top/next/depth on the following clock edge.
module operand_stack
   import stack_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  stack_op_t                  op,
   input  logic                       op_valid,
   output logic                       op_ready,
   input  logic [WIDTH-1:0]           push_data,
   output logic [WIDTH-1:0]           top,
   output logic [WIDTH-1:0]           next,
   output logic [$clog2(DEPTH):0]     depth,
   output logic                       empty,
   output logic                       full,
   output logic                       err,
   output err_code_t                  err_code
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [DW-1:0]    depth_q, depth_d;
   stack_state_t     state_q, state_d;
   err_code_t        err_code_q, err_code_d;

   logic [AW-1:0]    tos_idx, nos_idx, new_idx;
   logic [WIDTH-1:0] tos_val, nos_val;
   logic             has1, has2, is_full, accept;

   logic             wr_a_en, wr_b_en;
   logic [AW-1:0]    wr_a_idx, wr_b_idx;
   logic [WIDTH-1:0] wr_a_data, wr_b_data;

   // Indices wrap harmlessly when depth is too small; has1/has2 mask the reads.
   assign tos_idx = AW'(depth_q - DW'(1));
   assign nos_idx = AW'(depth_q - DW'(2));
   assign new_idx = depth_q[AW-1:0];
   assign tos_val = mem_q[tos_idx];
   assign nos_val = mem_q[nos_idx];
   assign has1    = (depth_q != '0);
   assign has2    = (depth_q >= DW'(2));
   assign is_full = (depth_q == DW'(DEPTH));

   assign op_ready = (state_q == ST_RUN) || (op == OP_CLR);
   assign accept   = op_valid && op_ready;

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      depth_d    = depth_q;
      state_d    = state_q;
      err_code_d = err_code_q;
      wr_a_en    = 1'b0;
      wr_a_idx   = new_idx;
      wr_a_data  = push_data;
      wr_b_en    = 1'b0;
      wr_b_idx   = nos_idx;
      wr_b_data  = tos_val;

      if (accept) begin
         unique case (op)
            OP_CLR: begin
               depth_d    = '0;
               state_d    = ST_RUN;
               err_code_d = ERR_NONE;
            end
            OP_PUSH: begin
               if (is_full) begin
                  state_d    = ST_ERROR;
                  err_code_d = ERR_OVERFLOW;
               end else begin
                  wr_a_en = 1'b1;
                  depth_d = depth_q + DW'(1);
               end
            end
            OP_DUP: begin
               if (!has1) begin
                  state_d    = ST_ERROR;
                  err_code_d = ERR_UNDERFLOW;
               end else if (is_full) begin
                  state_d    = ST_ERROR;
                  err_code_d = ERR_OVERFLOW;
               end else begin
                  wr_a_en   = 1'b1;
                  wr_a_data = tos_val;
                  depth_d   = depth_q + DW'(1);
               end
            end
            OP_POP: begin
               if (!has1) begin
                  state_d    = ST_ERROR;
                  err_code_d = ERR_UNDERFLOW;
               end else begin
                  depth_d = depth_q - DW'(1);
               end
            end
            OP_SWAP: begin
               if (!has2) begin
                  state_d    = ST_ERROR;
                  err_code_d = ERR_UNDERFLOW;
               end else begin
                  wr_a_en   = 1'b1;
                  wr_a_idx  = tos_idx;
                  wr_a_data = nos_val;
                  wr_b_en   = 1'b1;
               end
            end
            OP_ADD, OP_SUB: begin
               if (!has2) begin
                  state_d    = ST_ERROR;
                  err_code_d = ERR_UNDERFLOW;
               end else begin
                  wr_a_en   = 1'b1;
                  wr_a_idx  = nos_idx;
                  wr_a_data = (op == OP_ADD) ? nos_val + tos_val : nos_val - tos_val;
                  depth_d   = depth_q - DW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         depth_q    <= '0;
         state_q    <= ST_RUN;
         err_code_q <= ERR_NONE;
      end else begin
         depth_q    <= depth_d;
         state_q    <= state_d;
         err_code_q <= err_code_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; depth_q alone defines valid entries.
   always_ff @(posedge clk) begin
      if (wr_a_en) mem_q[wr_a_idx] <= wr_a_data;
      if (wr_b_en) mem_q[wr_b_idx] <= wr_b_data;
   end

   assign top      = has1 ? tos_val : '0;
   assign next     = has2 ? nos_val : '0;
   assign depth    = depth_q;
   assign empty    = !has1;
   assign full     = is_full;
   assign err      = (state_q == ST_ERROR);
   assign err_code = err_code_q;

endmodule

// File: tb/tb_operand_stack.sv
// Directed bench for operand_stack: arithmetic, overflow/underflow,
// error-state lockout, CLR recovery and asynchronous reset.
module tb_operand_stack;
   import stack_pkg::*;

   logic            clk;
   logic            rst_n;
   stack_op_t       op;
   logic            op_valid;
   logic            op_ready;
   logic [7:0]      push_data;
   logic [7:0]      top;
   logic [7:0]      next;
   logic [4:0]      depth;
   logic            empty;
   logic            full;
   logic            err;
   err_code_t       err_code;

   int errors = 0;
   int checks = 0;

   operand_stack #(.WIDTH(8), .DEPTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .op        (op),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .push_data (push_data),
      .top       (top),
      .next      (next),
      .depth     (depth),
      .empty     (empty),
      .full      (full),
      .err       (err),
      .err_code  (err_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic do_op(input stack_op_t o, input logic [7:0] d);
      @(negedge clk);
      op        = o;
      push_data = d;
      op_valid  = 1'b1;
      @(posedge clk);
      #1;
      op_valid  = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      op        = OP_NOP;
      op_valid  = 1'b0;
      push_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_depth", 32'(depth), 32'd0);
      check("rst_top", 32'(top), 32'd0);
      check("rst_next", 32'(next), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_err", 32'(err), 32'd0);
      check("rst_err_code", 32'(err_code), 32'd0);
      check("rst_ready", 32'(op_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic push
      do_op(OP_PUSH, 8'd5);
      check("push5_top", 32'(top), 32'd5);
      check("push5_depth", 32'(depth), 32'd1);
      do_op(OP_PUSH, 8'd7);
      check("push7_top", 32'(top), 32'd7);
      check("push7_next", 32'(next), 32'd5);
      check("push7_depth", 32'(depth), 32'd2);
      check("push7_err", 32'(err), 32'd0);

      // Arithmetic: 5+7, 12-3, 9-10 wraps
      do_op(OP_ADD, 8'd0);
      check("add_top", 32'(top), 32'd12);
      check("add_depth", 32'(depth), 32'd1);
      check("add_next", 32'(next), 32'd0);
      do_op(OP_PUSH, 8'd3);
      do_op(OP_SUB, 8'd0);
      check("sub_top", 32'(top), 32'd9);
      check("sub_depth", 32'(depth), 32'd1);
      do_op(OP_PUSH, 8'd10);
      do_op(OP_SUB, 8'd0);
      check("sub_wrap_top", 32'(top), 32'd255);
      check("sub_wrap_depth", 32'(depth), 32'd1);

      // DUP, SWAP, POP: [255] -> [255,255] -> [255,255,1] -> [255,1,255] -> [255,1]
      do_op(OP_DUP, 8'd0);
      check("dup_top", 32'(top), 32'd255);
      check("dup_next", 32'(next), 32'd255);
      check("dup_depth", 32'(depth), 32'd2);
      do_op(OP_PUSH, 8'd1);
      do_op(OP_SWAP, 8'd0);
      check("swap_top", 32'(top), 32'd255);
      check("swap_next", 32'(next), 32'd1);
      check("swap_depth", 32'(depth), 32'd3);
      do_op(OP_POP, 8'd0);
      check("pop_top", 32'(top), 32'd1);
      check("pop_next", 32'(next), 32'd255);
      check("pop_depth", 32'(depth), 32'd2);

      do_op(OP_CLR, 8'd0);
      check("clr1_depth", 32'(depth), 32'd0);
      check("clr1_top", 32'(top), 32'd0);

      // Fill to full, then overflow
      for (int i = 1; i <= 16; i++) do_op(OP_PUSH, 8'(i));
      check("full_flag", 32'(full), 32'd1);
      check("full_top", 32'(top), 32'd16);
      check("full_next", 32'(next), 32'd15);
      check("full_depth", 32'(depth), 32'd16);
      do_op(OP_PUSH, 8'd17);
      check("ovf_err", 32'(err), 32'd1);
      check("ovf_code", 32'(err_code), 32'd1);
      check("ovf_top", 32'(top), 32'd16);
      check("ovf_depth", 32'(depth), 32'd16);
      check("ovf_ready", 32'(op_ready), 32'd0);

      // Error state ignores everything but CLR
      do_op(OP_PUSH, 8'd9);
      check("errlock_push_top", 32'(top), 32'd16);
      check("errlock_push_depth", 32'(depth), 32'd16);
      do_op(OP_POP, 8'd0);
      check("errlock_pop_depth", 32'(depth), 32'd16);
      check("errlock_code", 32'(err_code), 32'd1);
      op = OP_CLR;
      #1;
      check("err_ready_clr", 32'(op_ready), 32'd1);
      do_op(OP_CLR, 8'd0);
      check("clr2_depth", 32'(depth), 32'd0);
      check("clr2_empty", 32'(empty), 32'd1);
      check("clr2_err", 32'(err), 32'd0);
      check("clr2_code", 32'(err_code), 32'd0);
      check("clr2_ready", 32'(op_ready), 32'd1);

      // Underflow cases
      do_op(OP_POP, 8'd0);
      check("unf_pop_code", 32'(err_code), 32'd2);
      check("unf_pop_depth", 32'(depth), 32'd0);
      check("unf_pop_err", 32'(err), 32'd1);
      do_op(OP_CLR, 8'd0);
      do_op(OP_PUSH, 8'd4);
      do_op(OP_SWAP, 8'd0);
      check("unf_swap_code", 32'(err_code), 32'd2);
      check("unf_swap_top", 32'(top), 32'd4);
      check("unf_swap_depth", 32'(depth), 32'd1);
      do_op(OP_CLR, 8'd0);
      do_op(OP_ADD, 8'd0);
      check("unf_add_code", 32'(err_code), 32'd2);
      do_op(OP_CLR, 8'd0);

      // NOP and idle cycles leave the stack alone
      do_op(OP_PUSH, 8'd1);
      do_op(OP_PUSH, 8'd2);
      do_op(OP_PUSH, 8'd3);
      do_op(OP_NOP, 8'd77);
      check("nop_depth", 32'(depth), 32'd3);
      check("nop_top", 32'(top), 32'd3);
      @(negedge clk);
      op = OP_PUSH;
      push_data = 8'd88;
      @(posedge clk);
      #1;
      check("idle_depth", 32'(depth), 32'd3);
      check("idle_next", 32'(next), 32'd2);

      // Asynchronous reset in the middle of a cycle with a PUSH presented
      @(negedge clk);
      op        = OP_PUSH;
      push_data = 8'd99;
      op_valid  = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_depth", 32'(depth), 32'd0);
      check("arst_top", 32'(top), 32'd0);
      check("arst_next", 32'(next), 32'd0);
      check("arst_err", 32'(err), 32'd0);
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      check("arst_hold_depth", 32'(depth), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("arst_after_depth", 32'(depth), 32'd0);
      check("arst_after_empty", 32'(empty), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/operand_stack.md
OPERAND_STACK -- requirements
Module: operand_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16: number of stack entries (power of two).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port op  input  3  opcode (stack_op_t): NOP, PUSH, POP, DUP, SWAP, ADD, SUB, CLR.
REQ-006 SHALL have port op_valid  input  1  op presented this cycle.
REQ-007 SHALL have port op_ready  output  1  block accepts op this cycle.
REQ-008 SHALL have port push_data  input  WIDTH  operand for PUSH.
REQ-009 SHALL have port top  output  WIDTH  entry at top of stack (TOS); 0 when empty.
REQ-010 SHALL have port next  output  WIDTH  entry below TOS (NOS); 0 when depth < 2.
REQ-011 SHALL have port depth  output  $clog2(DEPTH)+1  current entry count, 0..DEPTH.
REQ-012 SHALL have ports empty, full  output  1 each  depth==0, depth==DEPTH.
REQ-013 SHALL have port err  output  1  sticky error flag (overflow or underflow).
REQ-014 SHALL have port err_code  output  2  NONE=0, OVERFLOW=1, UNDERFLOW=2.

Function
REQ-015 SHALL implement states RUN and ERROR; op_ready = (state==RUN) or (op==CLR).
REQ-016 SHALL accept an op on a rising edge where op_valid && op_ready; effects visible on top/next/depth the following cycle (1-cycle latency).
REQ-017 SHALL: PUSH writes push_data above TOS, depth+1.
REQ-018 SHALL: POP discards TOS, depth-1.
REQ-019 SHALL: DUP copies TOS to a new entry, depth+1.
REQ-020 SHALL: SWAP exchanges TOS and NOS, depth unchanged.
REQ-021 SHALL: ADD/SUB replace TOS,NOS with (NOS+TOS)/(NOS-TOS) modulo 2^WIDTH, depth-1; carry/borrow discarded.
REQ-022 SHALL: CLR sets depth 0, err 0, err_code NONE, state RUN; accepted in any state.
REQ-023 SHALL treat PUSH/DUP at full as overflow: stack unchanged, err=1, err_code=OVERFLOW, go ERROR.
REQ-024 SHALL treat POP/DUP/SWAP at depth<required (POP,DUP:1; SWAP,ADD,SUB:2) as underflow: stack unchanged, err=1, err_code=UNDERFLOW, go ERROR.
REQ-025 SHALL, in ERROR, ignore every op except CLR; stack contents and outputs hold.
REQ-026 SHALL treat NOP and cycles with op_valid=0 as no change.
REQ-027 SHALL keep entries above depth don't-care; top/next SHALL still read 0 per REQ-009/010.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force state RUN, depth 0, err 0, err_code NONE, top 0, next 0; storage array need not be reset.
REQ-029 SHALL abandon any op in flight when reset asserts mid-cycle; no partial update survives.

Structure
REQ-030 SHALL place stack_op_t and err_code_t enums in shared package stack_pkg, also used by the stack machine core.
REQ-031 SHALL be a single module, register-array storage plus stack pointer; no sub-module.

Verification
REQ-032 Reset, PUSH 5, PUSH 7 -> top=7, next=5, depth=2, err=0.
REQ-033 From [5,7]: ADD -> top=12, depth=1; PUSH 3, SUB -> top=9; PUSH 10, SUB from [9,10] -> top=255 (wrap).
REQ-034 16 PUSHes 1..16 -> full=1, top=16; 17th PUSH -> err=1, err_code=1, top=16, op_ready=0.
REQ-035 In ERROR, PUSH 9 and POP ignored; CLR -> depth=0, empty=1, err=0, op_ready=1.
REQ-036 Empty stack: POP -> err_code=2, depth=0; CLR; PUSH 4, SWAP -> err_code=2, top=4.
REQ-037 Depth 3, assert rst_n=0 mid-cycle with PUSH valid -> depth=0, top=0, err=0 immediately, before next clk edge.
